// File: rtl/qar_dmem_ctrl.sv
// Word-addressed data-memory controller for the qar_core external data port.
// It owns an SRAM array, adds fixed wait states per access and rejects misaligned or out-of-range addresses.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | waiting for i_mem_valid; latches the request when it arrives
//  S_WAIT   | wait-state countdown (only entered when WAIT_STATES > 0)
//  S_ACCESS | address decode, array write or read, pulse o_mem_ready/o_err
//  S_RESP   | turnaround cycle; i_mem_valid is ignored
module qar_dmem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_valid,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic        o_err,
    output logic [31:0] o_err_addr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_wait_cnt;
    logic [3:0]              w_wait_cnt_nxt;
    logic                    w_accept;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    w_access;
    logic                    w_bad;
    logic                    w_mem_wr;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             r_mem [DEPTH];

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_mem_valid) begin
                    w_accept       = 1'b1;
                    w_wait_cnt_nxt = LP_WAIT;
                    w_state_nxt    = (LP_WAIT != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                // terminal count is 1; <= also recovers from an impossible 0
                if (r_wait_cnt <= 4'd1) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_access = (r_state == S_ACCESS);
    assign w_idx    = r_addr[ADDR_WIDTH+1:2];
    assign w_bad    = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_WIDTH+2] != '0);
    assign w_mem_wr = w_access && r_we && !w_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            o_mem_ready <= 1'b0;
            o_err       <= 1'b0;
            o_mem_rdata <= 32'd0;
            o_err_addr  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            o_mem_ready <= w_access;
            o_err       <= w_access && w_bad;
            if (w_accept) begin
                r_we    <= i_mem_we;
                r_addr  <= i_mem_addr;
                r_wdata <= i_mem_wdata;
            end
            if (w_access && !r_we) begin
                o_mem_rdata <= w_bad ? 32'd0 : r_mem[w_idx];
            end
            if (w_access && w_bad) begin
                o_err_addr <= r_addr;
            end
        end
    end

    // The array has no reset; contents are undefined until written.
    always_ff @(posedge i_clk) begin
        if (w_mem_wr) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_qar_dmem_ctrl.sv
// Bench for qar_dmem_ctrl: two instances (0 and 3 wait states) driven with directed and random
// accesses and compared against a word-array reference model.
module tb_qar_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready0, ready1, err0, err1;
    logic [31:0] rdata0, rdata1, eaddr0, eaddr1;
    logic [1:0]  ready;
    logic [1:0]  err;
    logic [31:0] rdata [2];
    logic [31:0] eaddr [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl    [2][256];
    bit          known  [2][256];
    logic [31:0] exp_ea [2];

    always #5 clk = ~clk;

    assign ready    = {ready1, ready0};
    assign err      = {err1, err0};
    assign rdata[0] = rdata0;
    assign rdata[1] = rdata1;
    assign eaddr[0] = eaddr0;
    assign eaddr[1] = eaddr1;

    qar_dmem_ctrl #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(v[0]), .i_mem_we(we[0]),
        .i_mem_addr(addr[0]), .i_mem_wdata(wdata[0]), .o_mem_ready(ready0),
        .o_mem_rdata(rdata0), .o_err(err0), .o_err_addr(eaddr0)
    );

    qar_dmem_ctrl #(.DEPTH(256), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_valid(v[1]), .i_mem_we(we[1]),
        .i_mem_addr(addr[1]), .i_mem_wdata(wdata[1]), .o_mem_ready(ready1),
        .o_mem_rdata(rdata1), .o_err(err1), .o_err_addr(eaddr1)
    );

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after the acceptance edge; counts edges until ready is seen.
    task automatic wait_ready(input int d, input int lat_exp);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!ready[d] && k < 64);
        check("latency", k, lat_exp);
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd);
        bit          bad;
        logic [31:0] exp_rd;
        bit          chk_rd;
        @(negedge clk);
        v[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        exp_rd = rdata[d];
        chk_rd = 1'b1;
        bad = is_bad(a);
        if (bad) begin
            exp_ea[d] = a;
            if (!w) exp_rd = 32'd0;
        end else if (w) begin
            mdl[d][a[9:2]]   = wd;
            known[d][a[9:2]] = 1'b1;
        end else begin
            exp_rd = mdl[d][a[9:2]];
            chk_rd = known[d][a[9:2]];
        end
        @(posedge clk);
        wait_ready(d, ws_of(d) + 1);
        rd = rdata[d];
        check("err", {31'd0, err[d]}, {31'd0, bad});
        if (chk_rd) check(w ? "rdata_hold" : "rdata", rdata[d], exp_rd);
        check("err_addr", eaddr[d], exp_ea[d]);
        @(posedge clk);
        #1;
        check("ready_pulse", {31'd0, ready[d]}, 32'd0);
        check("err_pulse", {31'd0, err[d]}, 32'd0);
        v[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] sum_hw, sum_sw, a;
        int          pulses, sel, idx;

        rst_n = 1'b0;
        v = 2'b00; we = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr[d] = 32'd0; wdata[d] = 32'd0; exp_ea[d] = 32'd0;
            for (int i = 0; i < 256; i++) begin
                known[d][i] = 1'b0;
                mdl[d][i]   = 32'd0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", {31'd0, ready[d]}, 32'd0);
            check("rst_err", {31'd0, err[d]}, 32'd0);
            check("rst_rdata", rdata[d], 32'd0);
            check("rst_err_addr", eaddr[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // write then read, no wait states
        xfer(0, 1'b1, 32'h40, 32'h1234_5678, rd);
        xfer(0, 1'b0, 32'h40, 32'h0, rd);

        // out-of-range write must not alias onto word 0
        xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, rd);
        xfer(0, 1'b1, 32'h400, 32'hFFFF_FFFF, rd);
        xfer(0, 1'b0, 32'h0, 32'h0, rd);
        xfer(0, 1'b0, 32'h400, 32'h0, rd);

        // misaligned read after a nonzero read
        xfer(0, 1'b0, 32'h40, 32'h0, rd);
        xfer(0, 1'b0, 32'h42, 32'h0, rd);

        // valid held through the turnaround cycle: one pulse, one write
        @(negedge clk);
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'h0BAD_BEEF;
        mdl[0][32] = 32'h0BAD_BEEF; known[0][32] = 1'b1;
        pulses = 0;
        @(posedge clk);
        repeat (2) begin
            @(posedge clk); #1;
            if (ready[0]) pulses++;
        end
        v[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ready[0]) pulses++;
        end
        check("held_pulses", pulses, 1);
        xfer(0, 1'b0, 32'h80, 32'h0, rd);

        // three wait states: latency 4, next acceptance at E6
        xfer(1, 1'b1, 32'h0, 32'h1111_0000, rd);
        xfer(1, 1'b1, 32'h4, 32'h2222_0004, rd);
        @(negedge clk);
        v[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        @(posedge clk);
        wait_ready(1, 4);
        check("tp_rdata0", rdata[1], 32'h1111_0000);
        @(posedge clk); #1;
        check("tp_ready_low", {31'd0, ready[1]}, 32'd0);
        addr[1] = 32'h4;
        @(posedge clk);
        wait_ready(1, 4);
        check("tp_rdata1", rdata[1], 32'h2222_0004);
        @(posedge clk); #1;
        v[1] = 1'b0;

        // reset while ready/err are high clears them at once
        xfer(1, 1'b0, 32'h401, 32'h0, rd);
        @(negedge clk);
        v[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h42;
        @(posedge clk);
        @(posedge clk); #1;
        check("pre_rst_ready", {31'd0, ready[0]}, 32'd1);
        check("pre_rst_err", {31'd0, err[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_ready_async", {31'd0, ready[0]}, 32'd0);
        check("rst_err_async", {31'd0, err[0]}, 32'd0);
        check("rst_err_addr0", eaddr[0], 32'd0);
        check("rst_err_addr1", eaddr[1], 32'd0);
        v[0] = 1'b0;
        exp_ea[0] = 32'd0; exp_ea[1] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // reset in WAIT drops the write; held valid is accepted as new after release
        xfer(1, 1'b1, 32'h8, 32'h5555_5555, rd);
        @(negedge clk);
        v[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'hAAAA_AAAA;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_wait_ready", {31'd0, ready[1]}, 32'd0);
        check("rst_wait_rdata", rdata[1], 32'd0);
        we[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        wait_ready(1, 4);
        check("rst_read_prior", rdata[1], 32'h5555_5555);
        check("rst_read_err", {31'd0, err[1]}, 32'd0);
        @(posedge clk); #1;
        v[1] = 1'b0;

        // randomized mix plus sum regression over words 0..5
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) xfer(d, 1'b1, 32'(i * 4), $urandom, rd);
            for (int i = 0; i < 30; i++) begin
                sel = $urandom_range(0, 3);
                idx = $urandom_range(0, 5);
                case (sel)
                    0, 1:    a = 32'(idx * 4);
                    2:       a = 32'(idx * 4 + $urandom_range(1, 3));
                    default: a = ($urandom & ~32'h3FF) | 32'h400;
                endcase
                xfer(d, 1'($urandom_range(0, 1)), a, $urandom, rd);
            end
            sum_hw = 32'd0;
            sum_sw = 32'd0;
            for (int i = 0; i < 6; i++) begin
                xfer(d, 1'b0, 32'(i * 4), 32'h0, rd);
                sum_hw = sum_hw + rd;
                sum_sw = sum_sw + mdl[d][i];
            end
            check("sum", sum_hw, sum_sw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
